// File: rtl/booth_iter_multiplier.sv
// Iterative radix-4 Booth multiplier for the integer pipe.
// Each BUSY cycle retires DIGITS_PER_CYCLE Booth digits of the recoded iB and
// adds their weighted partial products into a 2*EXT-bit accumulator.
// The result half (low or high) is captured once, on entry to DONE.
module booth_iter_multiplier #(
  parameter int WIDTH            = 64,
  parameter int DIGITS_PER_CYCLE = 2
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [1:0]       iMode,
  input  logic             iHigh,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oBusy
);
  localparam int EXT  = WIDTH + 2;
  localparam int NDIG = EXT / 2;
  localparam int ITER = (NDIG + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
  localparam int PW   = 2 * EXT;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int SHW  = $clog2(PW);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state, state_next;
  logic                   accept, zero_op, last;
  logic                   a_signed, b_signed;
  logic signed [EXT-1:0]  a_ext, b_ext;
  logic signed [EXT-1:0]  a_reg;
  logic signed [EXT:0]    b_sh;
  logic                   high_reg;
  logic [PW-1:0]          a_pw;
  logic [PW-1:0]          pp_w [DIGITS_PER_CYCLE];
  logic [PW-1:0]          iter_sum, acc, acc_next;
  logic [CW-1:0]          cnt;
  logic [SHW-1:0]         shamt;
  logic [WIDTH-1:0]       result_q, result_sel;

  // Booth digit decode: returns {negate, partial product before weighting}.
  // Negation is one's complement here; the +1 is injected at the digit LSB.
  function automatic logic [PW:0] booth_pp(input logic [2:0] trip,
                                           input logic [PW-1:0] a_val);
    logic [PW-1:0] mag;
    logic          neg;
    mag = '0;
    neg = 1'b0;
    case (trip)
      3'b001, 3'b010: mag = a_val;
      3'b011:         mag = a_val << 1;
      3'b100:         begin mag = a_val << 1; neg = 1'b1; end
      3'b101, 3'b110: begin mag = a_val;      neg = 1'b1; end
      default:        mag = '0;
    endcase
    return {neg, neg ? ~mag : mag};
  endfunction

  // Mode 10 is reserved and decodes like 11 (unsigned x unsigned).
  assign a_signed = (iMode == 2'b00) || (iMode == 2'b01);
  assign b_signed = (iMode == 2'b00);
  assign a_ext    = a_signed ? {{2{iA[WIDTH-1]}}, iA} : {2'b00, iA};
  assign b_ext    = b_signed ? {{2{iB[WIDTH-1]}}, iB} : {2'b00, iB};
  assign zero_op  = (iA == '0) || (iB == '0);
  assign accept   = (state == IDLE) && iValid && !iFlush;
  assign last     = (state == BUSY) && (cnt == CW'(ITER - 1));
  assign a_pw     = {{EXT{a_reg[EXT-1]}}, a_reg};

  // Digits of this iteration sit at the bottom of b_sh; b_sh[0] is b[-1].
  // Once shifted past the top, the arithmetic shift feeds copies of the sign
  // bit, so digits with index >= NDIG decode as 000/111 and contribute zero.
  for (genvar j = 0; j < DIGITS_PER_CYCLE; j++) begin : g_digit
    logic [PW:0] coded;
    assign coded   = booth_pp(b_sh[2*j+2:2*j], a_pw);
    assign pp_w[j] = (coded[PW-1:0] << (2*j)) + ({{(PW-1){1'b0}}, coded[PW]} << (2*j));
  end

  // Sum this iteration's partial products and weight them by the iteration.
  always_comb begin
    iter_sum = '0;
    for (int j = 0; j < DIGITS_PER_CYCLE; j++) iter_sum = iter_sum + pp_w[j];
    acc_next   = acc + (iter_sum << shamt);
    result_sel = high_reg ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; flush wins over every other transition.
  always_comb begin
    state_next = state;
    if (iFlush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (iValid) state_next = zero_op ? DONE : BUSY;
        BUSY:    if (last)   state_next = DONE;
        DONE:    if (iReady) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Handshake outputs decode directly from the state.
  always_comb begin
    oReady = (state == IDLE);
    oValid = (state == DONE);
    oBusy  = (state == BUSY);
  end

  // Accumulator, iteration counter, weight and captured result.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      acc      <= '0;
      cnt      <= '0;
      shamt    <= '0;
      result_q <= '0;
    end else if (accept) begin
      acc   <= '0;
      cnt   <= '0;
      shamt <= '0;
      if (zero_op) result_q <= '0;
    end else if ((state == BUSY) && !iFlush) begin
      acc   <= acc_next;
      cnt   <= cnt + 1'b1;
      shamt <= shamt + SHW'(2 * DIGITS_PER_CYCLE);
      if (last) result_q <= result_sel;
    end
  end

  // Operand capture at the handshake; the recoded operand steps down per iteration.
  always_ff @(posedge iClk) begin
    if (accept) begin
      a_reg    <= a_ext;
      b_sh     <= {b_ext, 1'b0};
      high_reg <= iHigh;
    end else if (state == BUSY) begin
      b_sh <= b_sh >>> (2 * DIGITS_PER_CYCLE);
    end
  end

  assign oResult = result_q;

endmodule

// File: tb/tb_booth_iter_multiplier.sv
// Bench for booth_iter_multiplier: a 64-bit/2-digit instance driven with
// directed vectors and checked every cycle against a timing/product model,
// plus a set of smaller parameterisations exercised with random operands.
module tb_booth_iter_multiplier;
  logic        clk;
  logic        rst_n, sw_rst_n;
  logic        valid, flush, ready, high;
  logic [1:0]  mode;
  logic [63:0] a, b;
  logic        oready, ovalid, busy;
  logic [63:0] result;

  int          total, bad, cyc, sw_done;
  bit          chk_en, pend;
  int          issue_c, due_c;
  logic [63:0] exp_res, got_res;
  bit          e_valid, e_ready, e_busy;

  booth_iter_multiplier #(.WIDTH(64), .DIGITS_PER_CYCLE(2)) u_dut (
    .iClk(clk), .iRstN(rst_n), .iValid(valid), .oReady(oready),
    .iA(a), .iB(b), .iMode(mode), .iHigh(high), .iFlush(flush),
    .oValid(ovalid), .iReady(ready), .oResult(result), .oBusy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h cyc=%0d", name, got, want, cyc);
    end
  endtask

  // Exact product from plain wide arithmetic, then pick the requested half.
  function automatic logic [63:0] model(input logic [63:0] ta, input logic [63:0] tb,
                                        input logic [1:0] tm, input logic th, input int w);
    logic signed [131:0] ae, be, p, one;
    logic [63:0]         mask;
    one  = 1;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ae   = $signed({68'd0, ta & mask});
    be   = $signed({68'd0, tb & mask});
    if ((tm == 2'b00 || tm == 2'b01) && (((ta >> (w - 1)) & 64'd1) != 0)) ae = ae - (one <<< w);
    if ((tm == 2'b00) && (((tb >> (w - 1)) & 64'd1) != 0)) be = be - (one <<< w);
    p = ae * be;
    if (th) return 64'(p >>> w) & mask;
    return 64'(p) & mask;
  endfunction

  // Every cycle: outputs must match where the model says the operation is.
  always @(negedge clk) begin
    if (chk_en) begin
      e_valid = pend && (cyc >= due_c);
      e_ready = !pend || (cyc == issue_c);
      e_busy  = pend && (cyc > issue_c) && (cyc < due_c);
      chk("ovalid", 64'(ovalid), 64'(e_valid));
      chk("oready", 64'(oready), 64'(e_ready));
      chk("obusy",  64'(busy),   64'(e_busy));
      if (e_valid) chk("oresult", result, exp_res);
      if (e_valid && ovalid && ready && !flush) begin
        got_res = result;
        pend    = 1'b0;
      end
    end
  end

  // Present one request in the current cycle; returns one cycle later.
  task automatic issue(input logic [63:0] ta, input logic [63:0] tb,
                       input logic [1:0] tm, input logic th);
    a = ta; b = tb; mode = tm; high = th; valid = 1'b1;
    exp_res = model(ta, tb, tm, th, 64);
    issue_c = cyc;
    due_c   = cyc + (((ta == 0) || (tb == 0)) ? 1 : 18);
    pend    = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    mode = 2'($urandom);
    high = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && pend; k++) begin
      @(posedge clk); #1;
    end
    if (pend) begin
      total++; bad++;
      $display("FAIL timeout: result never transferred cyc=%0d", cyc);
      pend = 1'b0;
    end
  endtask

  task automatic run(input logic [63:0] ta, input logic [63:0] tb, input logic [1:0] tm,
                     input logic th, input logic [63:0] lit, input string name);
    issue(ta, tb, tm, th);
    wait_idle();
    chk(name, got_res, lit);
  endtask

  // Smaller parameterisations, random operands across all modes and halves.
  for (genvar g = 0; g < 8; g++) begin : g_sw
    localparam int SW   = (g < 3) ? 8 : (g < 5) ? 16 : 64;
    localparam int SD   = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 5 : (g == 3) ? 2 :
                          (g == 4) ? 9 : (g == 5) ? 1 : (g == 6) ? 3 : 33;
    localparam int SN   = (SW + 2) / 2;
    localparam int SLAT = (SN + SD - 1) / SD + 1;
    logic          s_valid, s_oready, s_ovalid, s_high, s_busy;
    logic [SW-1:0] s_a, s_b, s_res;
    logic [1:0]    s_mode;

    booth_iter_multiplier #(.WIDTH(SW), .DIGITS_PER_CYCLE(SD)) u_sw (
      .iClk(clk), .iRstN(sw_rst_n), .iValid(s_valid), .oReady(s_oready),
      .iA(s_a), .iB(s_b), .iMode(s_mode), .iHigh(s_high), .iFlush(1'b0),
      .oValid(s_ovalid), .iReady(1'b1), .oResult(s_res), .oBusy(s_busy)
    );

    initial begin
      logic [63:0] ra, rb, er;
      int          n, lat;
      s_valid = 1'b0; s_a = '0; s_b = '0; s_mode = 2'b00; s_high = 1'b0;
      wait (sw_rst_n == 1'b1);
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if (i == 0) begin ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = ra; end
        if (i == 1) begin ra = 64'd1 << (SW - 1); rb = ra; end
        if (i == 2) rb = 64'd0;
        s_a = SW'(ra); s_b = SW'(rb); s_mode = 2'(i % 4); s_high = i[2] ^ i[0];
        er  = model(64'(s_a), 64'(s_b), s_mode, s_high, SW);
        lat = ((s_a == '0) || (s_b == '0)) ? 1 : SLAT;
        chk($sformatf("sw%0d_ready", g), 64'(s_oready), 64'd1);
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        n = 1;
        if (lat > 1) chk($sformatf("sw%0d_busy", g), 64'(s_busy), 64'd1);
        while (!s_ovalid && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
        chk($sformatf("sw%0d_lat", g), 64'(n), 64'(lat));
        chk($sformatf("sw%0d_res", g), 64'(s_res), er);
      end
      sw_done++;
    end
  end

  initial begin
    total = 0; bad = 0; cyc = 0; sw_done = 0;
    chk_en = 1'b0; pend = 1'b0; got_res = '0; exp_res = '0; issue_c = 0; due_c = 0;
    rst_n = 1'b0; sw_rst_n = 1'b0;
    valid = 1'b0; flush = 1'b0; ready = 1'b1; high = 1'b0; mode = 2'b00; a = '0; b = '0;
    #1;
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_oready", 64'(oready), 64'd1);
    chk("rst_obusy",  64'(busy),   64'd0);
    chk("rst_result", result,      64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; sw_rst_n = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;

    run(-64'sd3, 64'd5, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1, "ss_m3x5_lo");
    run(-64'sd3, 64'd5, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "ss_m3x5_hi");
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "uu_max_hi");
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 64'h0000_0000_0000_0001, "uu_max_lo");
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "rsv_max_hi");
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "su_hi");
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b01, 1'b0, 64'h8000_0000_0000_0000, "su_lo");
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b00, 1'b1, 64'h0000_0000_0000_0000, "ss_min_hi");

    // Zero fast path held under back-pressure for five valid cycles.
    ready = 1'b0;
    issue(64'h1234, 64'd0, 2'b00, 1'b0);
    while (cyc < due_c + 5) begin @(posedge clk); #1; end
    ready = 1'b1;
    wait_idle();
    chk("zero_fast", got_res, 64'd0);

    // Flush in IDLE suppresses acceptance.
    valid = 1'b1; flush = 1'b1; a = 64'd3; b = 64'd3;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Flush on the seventh BUSY cycle, then a fresh request.
    issue(64'd100, 64'd200, 2'b00, 1'b0);
    while (cyc < issue_c + 7) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; pend = 1'b0;
    run(64'd3, 64'd7, 2'b00, 1'b0, 64'd21, "after_flush_3x7");

    // Flush while a result waits in DONE: it is dropped, never transferred.
    ready = 1'b0;
    issue(64'd7, 64'd9, 2'b11, 1'b0);
    while (cyc < due_c + 1) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; pend = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of BUSY.
    issue(64'd5, 64'd6, 2'b00, 1'b0);
    while (cyc < issue_c + 5) begin @(posedge clk); #1; end
    rst_n = 1'b0; pend = 1'b0;
    #1;
    chk("midrst_ovalid", 64'(ovalid), 64'd0);
    chk("midrst_oready", 64'(oready), 64'd1);
    chk("midrst_obusy",  64'(busy),   64'd0);
    chk("midrst_result", result,      64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run(64'd12, -64'sd12, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF70, "post_rst_12xm12");

    for (int i = 0; i < 6; i++) begin
      issue({$urandom, $urandom}, {$urandom, $urandom}, 2'(i % 4), 1'(i & 1));
      wait_idle();
    end

    for (int k = 0; k < 5000 && sw_done < 8; k++) @(posedge clk);
    if (sw_done < 8) begin
      total++; bad++;
      $display("FAIL sweep_timeout: done=%0d want=8", sw_done);
    end
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_iter_multiplier.md
Name: booth_iter_multiplier

Overview:
- Parametrised, iterative radix-4 Booth multiplier for the integer execution pipe.
- Recodes the multiplier operand into Booth digits and accumulates partial products. DIGITS_PER_CYCLE digits are consumed per clock.
- Supports signed×signed, signed×unsigned and unsigned×unsigned operation, with low-half or high-half result select.
- Sits behind the ALU issue stage with valid/ready handshakes on both sides; supports flush.

Parameters:
- WIDTH, 64, operand width in bits; must be even, ≥4.
- DIGITS_PER_CYCLE, 2, Booth digits retired per clock; 1..NDIG.
- Derived, not overridable: EXT = WIDTH+2, the operand extended length. NDIG = EXT/2. ITER = ceil(NDIG/DIGITS_PER_CYCLE).

Ports:
- iClk  in  1  clock.
- iRstN  in  1  asynchronous active-low reset.
- iValid  in  1  request valid.
- oReady  out  1  block can accept a request.
- iA  in  WIDTH  multiplicand.
- iB  in  WIDTH  multiplier; this operand is Booth-recoded.
- iMode  in  2  operand signedness. 00 = signed×signed. 01 = iA signed × iB unsigned. 11 = unsigned×unsigned. 10 is reserved and behaves as 11.
- iHigh  in  1  1 = return product[2*WIDTH-1:WIDTH]; 0 = return product[WIDTH-1:0].
- iFlush  in  1  abort any in-flight or pending operation.
- oValid  out  1  result valid.
- iReady  in  1  consumer accepts result.
- oResult  out  WIDTH  selected product half.
- oBusy  out  1  an operation is in flight (state BUSY).

Behaviour:
- Clock and reset: one clock, iClk. Reset iRstN is asynchronous and active-low.
- Reset values: state IDLE, oReady=1, oValid=0, oBusy=0, oResult=0. The accumulator and counter are cleared.
- Operand extension: both operands are extended to EXT bits, sign-extended if treated as signed, zero-extended otherwise. The product is computed exactly in 2*EXT bits; the selected half is taken from bits [2*WIDTH-1:0].
- Booth digit k uses extended-iB bits {b[2k+1], b[2k], b[2k-1]}, with b[-1]=0. Digit encoding:
  - 000 and 111 → 0
  - 001 and 010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101 and 110 → −A
- Negation is one's complement plus a carry injected at the digit's LSB position, matching existing partial-product conventions. The sum must be exact modulo 2^(2*EXT).
- State machine IDLE / BUSY / DONE:
  - IDLE: oReady=1. A handshake (iValid & oReady & ~iFlush) latches operands, mode and iHigh.
  - From IDLE, if extended iA==0 or extended iB==0 → DONE next cycle with result 0 (zero fast path). Otherwise → BUSY with counter=0.
  - BUSY: each cycle adds DIGITS_PER_CYCLE partial products, shifted by 2*DIGITS_PER_CYCLE per iteration. Digits with index ≥ NDIG contribute 0. The counter increments; at counter==ITER-1 → DONE.
  - DONE: oValid=1 and oResult is stable until iReady. On oValid & iReady → IDLE.
- Latency: a request accepted in cycle t gives oValid at t+ITER+1. Example: WIDTH=64, DPC=2 → ITER=17, oValid at t+18. The zero fast path gives oValid at t+1.
- Throughput: one operation in flight. oReady=0 in BUSY and DONE; there is no combinational ready-through from iReady.
- Flush: iFlush=1 in any state forces IDLE next cycle, drops oValid, and suppresses acceptance in the same cycle. A result presented in DONE with iFlush high is not considered transferred.
- Reset mid-operation: immediate return to IDLE; no stale oValid after reset deassertion.
- Output hold: oResult is only updated on entry to DONE and is stable while oValid=1 & iReady=0.
- Inputs are ignored outside the IDLE handshake; changing them during BUSY has no effect.

Test Plan:
- WIDTH=64, DPC=2, mode 00, iA=-3, iB=5, iHigh=0 → oResult=0xFFFF_FFFF_FFFF_FFF1 at exactly t+18. Same operands with iHigh=1 → 0xFFFF_FFFF_FFFF_FFFF.
- Mode 11, iA=iB=0xFFFF_FFFF_FFFF_FFFF, iHigh=1 → 0xFFFF_FFFF_FFFF_FFFE. Same with iHigh=0 → 0x0000_0000_0000_0001.
- Mode 01, iA=-1, iB=0x8000_0000_0000_0000: iHigh=1 → 0xFFFF_FFFF_FFFF_FFFF; iHigh=0 → 0x8000_0000_0000_0000. Mode 00 with the same operands, iHigh=1 → 0x0000_0000_0000_0000.
- Zero fast path: iA=0x1234, iB=0 → oValid one cycle after the handshake, oResult=0. Back-pressure: hold iReady=0 for 5 cycles → oValid and oResult stable, oReady=0.
- Flush at BUSY cycle 7, followed by a new request 3×7 → no oValid for the aborted op; the new op returns 21 with full latency. Asserting iRstN=0 mid-BUSY → all outputs at reset values immediately.
- Parameter sweep WIDTH∈{8,16,64}, DPC∈{1,2,3,NDIG}: random operands across all modes and iHigh, checked against a reference model product. Latency must equal ceil(NDIG/DPC)+1.
